// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
//
// Multicycle execute stage. Operands arrive from the register-file read ports.
// The unit performs one ALU operation, or one iterative shift-add multiply,
// at a time. It then presents a registered result together with a write-back
// destination and a one-cycle register-file write strobe.
//
// Handshake: `start` is sampled only in IDLE. `busy` is high from the cycle
// after acceptance through WB. `done` pulses for the single WB cycle.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous, active-high reset (aborts any state)
//   start   in   1      operation request, sampled in IDLE only
//   op      in   4      operation code (0..10 ALU, 11 MUL, 12..15 illegal)
//   rd_in   in   5      destination register number
//   a       in   WIDTH  operand A (read port a)
//   b       in   WIDTH  operand B (read port b)
//   busy    out  1      high in every state except IDLE
//   done    out  1      one-cycle pulse in WB
//   result  out  WIDTH  registered result, held until the next WB
//   wb_rd   out  5      write-back destination, valid while wb_en is high
//   wb_en   out  1      register-file write strobe (suppressed for rd 0)
//   zero    out  1      result == 0, updated on entry to WB
//   err     out  1      illegal opcode, pulses with done
//
// Configuration
//   EXEC_UNIT_MUL_EN : when defined, op 11 runs the MUL_ITER-cycle shift-add
//                      multiplier. When undefined, the multiplier state,
//                      counter and accumulator are not built, and op 11 is
//                      handled as an illegal opcode.
// -----------------------------------------------------------------------------
module exec_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [4:0]       rd_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       wb_rd,
    output logic             wb_en,
    output logic             zero,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
`ifdef EXEC_UNIT_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
`endif

    // The multiplier retires exactly WIDTH product bits, so the iteration
    // count has to match the operand width.
    generate
        if (MUL_ITER != WIDTH) begin : g_cfg_check
            $error("exec_unit: MUL_ITER must equal WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef EXEC_UNIT_MUL_EN
        S_MUL  = 2'd2,
`endif
        S_WB   = 2'd3
    } state_t;

    state_t           state;

    // Captured request. During MUL, opa/opb double as the shifting
    // multiplicand/multiplier, so no separate shift registers are needed.
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [3:0]       op_q;
    logic [4:0]       rd_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_err;

    // ALU operation on captured operands. SLT and SRA need an explicitly signed view.
    function automatic logic [WIDTH-1:0] alu_calc(
        input logic [3:0]       f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic        [4:0]       sh;
        xs = x;
        ys = y;
        sh = y[4:0];
        alu_calc = '0;
        case (f)
            OP_ADD:  alu_calc = x + y;
            OP_SUB:  alu_calc = x - y;
            OP_AND:  alu_calc = x & y;
            OP_OR:   alu_calc = x | y;
            OP_XOR:  alu_calc = x ^ y;
            OP_NOR:  alu_calc = ~(x | y);
            OP_SLT:  alu_calc = {{(WIDTH-1){1'b0}}, (xs < ys)};
            OP_SLTU: alu_calc = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_SLL:  alu_calc = x << sh;
            OP_SRL:  alu_calc = x >> sh;
            OP_SRA:  alu_calc = xs >>> sh;
            default: alu_calc = '0;
        endcase
    endfunction

    // Anything past SRA is illegal on the EXEC path. When the multiplier is
    // built, op 11 never reaches EXEC, so this single test covers both builds.
    function automatic logic op_illegal(input logic [3:0] f);
        op_illegal = (f > OP_SRA);
    endfunction

    assign alu_res = alu_calc(op_q, opa, opb);
    assign alu_err = op_illegal(op_q);

`ifdef EXEC_UNIT_MUL_EN
    localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

    logic [CNT_W-1:0] mul_cnt;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] acc_next;

    // Add the shifted multiplicand when the current multiplier LSB is set.
    assign acc_next = opb[0] ? (mul_acc + opa) : mul_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            wb_en  <= 1'b0;
            err    <= 1'b0;
            zero   <= 1'b0;
            result <= '0;
            wb_rd  <= '0;
`ifdef EXEC_UNIT_MUL_EN
            mul_cnt <= '0;
            mul_acc <= '0;
`endif
        end else begin
            case (state)
                // ---- IDLE: capture the request --------------------------
                S_IDLE: begin
                    if (start) begin
                        opa  <= a;
                        opb  <= b;
                        op_q <= op;
                        rd_q <= rd_in;
                        busy <= 1'b1;
`ifdef EXEC_UNIT_MUL_EN
                        if (op == OP_MUL) begin
                            mul_cnt <= '0;
                            mul_acc <= '0;
                            state   <= S_MUL;
                        end else begin
                            state   <= S_EXEC;
                        end
`else
                        state <= S_EXEC;
`endif
                    end
                end

                // ---- EXEC: single-cycle ALU, register into WB -----------
                S_EXEC: begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                    err    <= alu_err;
                    wb_rd  <= rd_q;
                    wb_en  <= (rd_q != 5'd0);
                    done   <= 1'b1;
                    state  <= S_WB;
                end

`ifdef EXEC_UNIT_MUL_EN
                // ---- MUL: one shift-add step per cycle ------------------
                S_MUL: begin
                    mul_acc <= acc_next;
                    opa     <= opa << 1;
                    opb     <= opb >> 1;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == CNT_W'(MUL_ITER - 1)) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                        err    <= 1'b0;
                        wb_rd  <= rd_q;
                        wb_en  <= (rd_q != 5'd0);
                        done   <= 1'b1;
                        state  <= S_WB;
                    end
                end
`endif

                // ---- WB: strobes were live this cycle; drop them --------
                S_WB: begin
                    done  <= 1'b0;
                    wb_en <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_unit
//
// Scoreboard bench for exec_unit. The driver issues each operation at the
// earliest cycle the unit is allowed to accept it. It pushes the expected
// response, computed by a plain-arithmetic reference model, into a queue. A
// negedge monitor pops and compares whenever `done` is seen. On every cycle
// it also checks `busy` against the expected busy window, and checks that
// result, wb_rd and zero hold between WB pulses.
// -----------------------------------------------------------------------------
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [4:0]  rd_in = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        zero;
    logic        err;

    exec_unit #(.WIDTH(32), .MUL_ITER(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rd_in  (rd_in),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wb_rd  (wb_rd),
        .wb_en  (wb_en),
        .zero   (zero),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        logic        z;
        logic        er;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    int          bfrom  = 1;
    int          bto    = 0;
    logic [31:0] last_res  = 32'd0;
    logic [4:0]  last_rd   = 5'd0;
    logic        last_zero = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_mul(input logic [3:0] o);
`ifdef EXEC_UNIT_MUL_EN
        return (o == 4'd11);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: results from the opcode definitions, using ordinary arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, output logic e);
        logic [4:0]  s;
        logic [63:0] p;
        s = y[4:0];
        e = 1'b0;
        case (o)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return ~(x | y);
            4'd6:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'd7:  return (x < y) ? 32'd1 : 32'd0;
            4'd8:  return x << s;
            4'd9:  return x >> s;
            4'd10: return x[31] ? ~((~x) >> s) : (x >> s);
            4'd11: begin
                if (is_mul(o)) begin
                    p = {32'd0, x} * {32'd0, y};
                    return p[31:0];
                end
                e = 1'b1;
                return 32'd0;
            end
            default: begin
                e = 1'b1;
                return 32'd0;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1 in a cycle where the unit is idle. Returns in the
    // first idle cycle after the operation, or just after an abort reset.
    // spur: pulse random starts while busy. abort: busy-cycle index at which
    // to assert reset (0 = none).
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input bit spur, input int abort);
        int          k;
        int          lat;
        exp_t        e;
        logic        er;
        logic [31:0] res;
        k      = cyc;
        res    = ref_alu(o, x, y, er);
        lat    = is_mul(o) ? 33 : 2;
        e.res  = res;
        e.rd   = r;
        e.wen  = (r != 5'd0);
        e.z    = (res == 32'd0);
        e.er   = er;
        e.cyc  = k + lat;
        q.push_back(e);
        bfrom  = k + 1;
        bto    = k + lat;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        rd_in  = r;
        @(posedge clk); #1;
        for (int i = 1; i <= lat; i++) begin
            if (i == abort) begin
                // A start presented alongside reset must also be dropped.
                rst   = 1'b1;
                q.delete();
                bto   = cyc;
                start = 1'b1;
                op    = 4'd0;
                a     = $urandom;
                b     = $urandom;
                rd_in = 5'd1;
                @(posedge clk); #1;
                rst   = 1'b0;
                start = 1'b0;
                return;
            end
            start = spur && ($urandom_range(0, 3) == 0);
            op    = 4'($urandom);
            a     = $urandom;
            b     = $urandom;
            rd_in = 5'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("busy", 32'(busy), 32'((cyc >= bfrom) && (cyc <= bto)));
            if (q.size() > 0 && q[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL late_done: no done seen, expected at cycle %0d, now %0d", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (done) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_done: done=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("result", result, e.res);
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_en", 32'(wb_en), 32'(e.wen));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("err", 32'(err), 32'(e.er));
                    last_res  = e.res;
                    last_rd   = e.rd;
                    last_zero = e.z;
                end
            end else begin
                chk("wb_en_idle", 32'(wb_en), 32'd0);
                chk("err_idle", 32'(err), 32'd0);
                chk("result_hold", result, last_res);
                chk("wb_rd_hold", 32'(wb_rd), 32'(last_rd));
                chk("zero_hold", 32'(zero), 32'(last_zero));
            end
            // Reset sampled at the coming edge clears the held outputs.
            if (rst) begin
                last_res  = 32'd0;
                last_rd   = 5'd0;
                last_zero = 1'b0;
            end
        end
    end

    initial begin
        int abort_at;
`ifdef EXEC_UNIT_MUL_EN
        abort_at = 10;
`else
        abort_at = 1;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Directed cases
        issue(4'd0,  32'hFFFF_FFFF, 32'd1,        5'd5,  1'b0, 0);
        issue(4'd10, 32'h8000_0000, 32'd4,        5'd7,  1'b0, 0);
        issue(4'd6,  32'hFFFF_FFFF, 32'd1,        5'd0,  1'b0, 0);
        issue(4'd11, 32'h0001_0003, 32'h0002_0005, 5'd12, 1'b1, 0);
        issue(4'd13, $urandom,      $urandom,     5'd3,  1'b0, 0);
        issue(4'd11, 32'd1234,      32'd5678,     5'd4,  1'b0, 0);
        issue(4'd11, 32'h0001_0003, 32'h0002_0005, 5'd6,  1'b0, abort_at);
        repeat (2) begin
            @(posedge clk); #1;
        end
        issue(4'd0,  32'd3,         32'd4,        5'd9,  1'b0, 0);
        issue(4'd8,  32'h0000_0001, 32'd0,        5'd2,  1'b0, 0);
        issue(4'd9,  32'hF000_0000, 32'd31,       5'd2,  1'b0, 0);

        // Randomized traffic, back-to-back or with short gaps
        for (int n = 0; n < 200; n++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            issue(4'($urandom), pick(), pick(), r, bit'($urandom_range(0, 1)), 0);
        end

        for (int i = 0; i < 100 && q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding at end", q.size());
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
